// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweep sequencer.
//   state_e    - sequencer FSM states
//   NUM_IN     - number of circuit inputs driven per row
//   TT_W       - truth-table width (one bit per row)
//   row_to_bit - maps row index k to its truth-table bit (MSB-first, row 0 -> bit 7)
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSample,
        StDone
    } state_e;

    localparam int unsigned NUM_IN = 3;
    localparam int unsigned TT_W   = 8;

    // Row 0 lands in the MSB so the table reads like the hex names of the designs.
    function automatic logic [2:0] row_to_bit(input logic [2:0] k);
        return 3'd7 - k;
    endfunction

endpackage

// File: rtl/sample_voter.sv
// sample_voter: majority vote and disagreement detection over a burst of samples.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - discard accumulated samples (takes priority over enable)
//   enable    - accumulate 'sample' at this edge
//   sample    - the bit being sampled
//   vote      - majority of all samples including the current one
//   disagree  - high when the samples (including the current one) are not all equal
// vote/disagree are combinational so they are valid during the last sample cycle.
module sample_voter #(
    parameter int unsigned SAMPLES = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic sample,
    output logic vote,
    output logic disagree
);

    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] seen_q;
    logic             ref_q;
    logic             all_eq_q;
    logic [CNT_W-1:0] ones_total;

    assign ones_total = ones_q + CNT_W'(sample);
    assign vote       = ones_total > CNT_W'(SAMPLES / 2);
    // A single sample can never disagree with itself.
    assign disagree   = (seen_q != '0) && (!all_eq_q || (sample != ref_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q   <= '0;
            seen_q   <= '0;
            ref_q    <= 1'b0;
            all_eq_q <= 1'b1;
        end else if (clear) begin
            ones_q   <= '0;
            seen_q   <= '0;
            ref_q    <= 1'b0;
            all_eq_q <= 1'b1;
        end else if (enable) begin
            ones_q <= ones_total;
            seen_q <= seen_q + CNT_W'(1);
            if (seen_q == '0) begin
                ref_q <= sample;
            end else if (sample != ref_q) begin
                all_eq_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps all 8 input rows of a 3-input/1-output circuit, settles, samples
// each row with a majority vote and assembles an MSB-first truth table.
//   clk, rst          - clock, asynchronous active-high reset
//   start             - begin a sweep (accepted only in idle, abort wins)
//   abort             - abandon a sweep in progress, no done pulse
//   expected          - reference truth table for match
//   circ_in1..3       - circuit inputs, circ_in1 is the row MSB
//   circ_out          - circuit output
//   busy              - sweep in progress
//   done              - one-cycle pulse, results valid
//   tt                - measured truth table
//   match             - tt == expected (set with done)
//   unstable          - per-row flag: samples disagreed
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    output logic            circ_in1,
    output logic            circ_in2,
    output logic            circ_in3,
    input  logic            circ_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic            match,
    output logic [TT_W-1:0] unstable
);

    state_e            state_q;
    logic [NUM_IN-1:0] row_q;
    logic [NUM_IN-1:0] circ_in_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              vote;
    logic              disagree;
    logic              last_settle;
    logic              last_sample;
    logic [TT_W-1:0]   tt_upd;
    logic [TT_W-1:0]   unstable_upd;

    assign last_settle = cnt_q == CNT_W'(SETTLE_CYCLES - 1);
    assign last_sample = cnt_q == CNT_W'(SAMPLES - 1);

    // Circuit inputs are a separate register so they hold the last row through idle.
    assign circ_in1 = circ_in_q[2];
    assign circ_in2 = circ_in_q[1];
    assign circ_in3 = circ_in_q[0];

    sample_voter #(
        .SAMPLES (SAMPLES),
        .CNT_W   (CNT_W)
    ) u_voter (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != StSample),
        .enable   (state_q == StSample),
        .sample   (circ_out),
        .vote     (vote),
        .disagree (disagree)
    );

    // Result vectors with the current row's vote merged in, used on the last sample.
    always_comb begin
        tt_upd       = tt;
        unstable_upd = unstable;
        tt_upd[row_to_bit(row_q)]       = vote;
        unstable_upd[row_to_bit(row_q)] = disagree;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            row_q     <= '0;
            circ_in_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt        <= '0;
            match     <= 1'b0;
            unstable  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    row_q <= '0;
                    cnt_q <= '0;
                    if (start && !abort) begin
                        state_q   <= StApply;
                        circ_in_q <= '0;
                        busy      <= 1'b1;
                        tt        <= '0;
                        unstable  <= '0;
                        match     <= 1'b0;
                    end
                end
                StApply: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        match   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (last_settle) begin
                        state_q <= StSample;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StSample: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        match   <= 1'b0;
                        cnt_q   <= '0;
                    end else if (last_sample) begin
                        tt       <= tt_upd;
                        unstable <= unstable_upd;
                        cnt_q    <= '0;
                        if (row_q == 3'd7) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            match   <= (tt_upd == expected);
                        end else begin
                            state_q   <= StApply;
                            row_q     <= row_q + 3'd1;
                            circ_in_q <= row_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;

    typedef struct {
        logic [7:0]  tt;
        logic [7:0]  unst;
        logic        match;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  expected;
    logic        c1, c2, c3;
    logic        circ_out;
    logic        busy, done, match;
    logic [7:0]  tt, unstable;
    logic [2:0]  circ_bus;

    logic        tog_en;
    logic        model_out;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned done_cnt;
    int unsigned pushes;
    exp_t        sb[$];
    exp_t        mon_e;

    tt_sweep_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .expected (expected),
        .circ_in1 (c1),
        .circ_in2 (c2),
        .circ_in3 (c3),
        .circ_out (circ_out),
        .busy     (busy),
        .done     (done),
        .tt       (tt),
        .match    (match),
        .unstable (unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign circ_bus = {c1, c2, c3};

    // 0x92 circuit: in1&in2&~in3 | ~in1&(in2 xnor in3). In toggle mode row 3 follows cyc[0].
    always_comb begin
        model_out = (c1 & c2 & ~c3) | (~c1 & ~(c2 ^ c3));
        circ_out  = (tog_en && circ_bus == 3'b011) ? cyc[0] : model_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.cyc);
                check("tt", {24'd0, tt}, {24'd0, mon_e.tt});
                check("unstable", {24'd0, unstable}, {24'd0, mon_e.unst});
                check("match", {31'd0, match}, {31'd0, mon_e.match});
            end
        end
    end

    // Start a sweep at the next falling edge and queue its expected result.
    // start is sampled at the following rising edge t0; done appears 57 cycles later,
    // i.e. while cyc == (cyc at drive time) + 57.
    task automatic issue_start(input logic [7:0] exp_val, input logic [7:0] tt_e,
                               input logic [7:0] un_e, input bit tog);
        exp_t e;
        @(negedge clk);
        expected = exp_val;
        start    = 1'b1;
        e.tt     = tt_e;
        // Row 3 samples fall on cyc = t0+25..t0+27; majority equals parity of drive-time cyc.
        if (tog) e.tt[4] = cyc[0];
        e.unst   = un_e;
        e.match  = (e.tt == exp_val);
        e.cyc    = cyc + 57;
        sb.push_back(e);
        pushes++;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("row0_driven", {29'd0, circ_bus}, 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("sweep_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_row(input logic [2:0] r);
        for (int i = 0; i < 100 && circ_bus != r; i++) @(negedge clk);
        check("reach_row", {29'd0, circ_bus}, {29'd0, r});
    endtask

    int unsigned saved_done;

    initial begin
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        pushes   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'h00;
        tog_en   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tt", {24'd0, tt}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_unstable", {24'd0, unstable}, 32'd0);
        check("rst_circ_in", {29'd0, circ_bus}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal sweep, matching reference.
        issue_start(8'h92, 8'h92, 8'h00, 1'b0);
        wait_drain();

        // Nominal sweep, wrong reference.
        issue_start(8'h96, 8'h92, 8'h00, 1'b0);
        wait_drain();
        check("inputs_hold_last_row", {29'd0, circ_bus}, 32'd7);

        // Toggling output during row 3.
        tog_en = 1'b1;
        issue_start(8'h92, 8'h92, 8'h10, 1'b1);
        wait_drain();
        tog_en = 1'b0;

        // Abort on entry to row 5: rows 0..4 -> tt = 1001_0xxx partial = 8'h90.
        @(negedge clk);
        expected = 8'h92;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_row(3'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tt", {24'd0, tt}, 32'h90);
        check("abort_unstable", {24'd0, unstable}, 32'd0);
        check("abort_match", {31'd0, match}, 32'd0);
        saved_done = done_cnt;
        repeat (70) @(negedge clk);
        check("abort_no_done", done_cnt, saved_done);
        issue_start(8'h92, 8'h92, 8'h00, 1'b0);
        wait_drain();

        // Asynchronous reset in row 2's sample window (rows 0,1 written -> tt = 8'h80).
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_row(3'd2);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_tt", {24'd0, tt}, 32'h80);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_tt", {24'd0, tt}, 32'd0);
        check("arst_match", {31'd0, match}, 32'd0);
        check("arst_unstable", {24'd0, unstable}, 32'd0);
        check("arst_circ_in", {29'd0, circ_bus}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saved_done = done_cnt;
        repeat (70) @(negedge clk);
        check("arst_no_done", done_cnt, saved_done);

        // Start pulses while busy must not disturb timing or add done pulses.
        issue_start(8'h92, 8'h92, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // start + abort together in idle: abort wins.
        repeat (2) @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        saved_done = done_cnt;
        repeat (70) @(negedge clk);
        check("start_abort_no_done", done_cnt, saved_done);

        check("done_per_start", done_cnt, pushes);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
